// File: rtl/step_sequencer.sv
// step_sequencer
//   Drives a 4-coil stepper motor one step per delay-counter period. A command
//   (step count, direction, inter-step delay, half/full step) is accepted in
//   IDLE. For every step the sequencer loads the external delay counter
//   (dly_start), runs it (dly_enable), waits for dly_done, and then advances
//   the coil phase index.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready = IDLE & !abort
//   cmd_steps/dir/delay/half  command fields, sampled on accept only
//   abort                 terminate current command, block acceptance in IDLE
//   dly_start/enable/value    load pulse, run enable and delay to the counter
//   dly_done              counter expiry, only observed in WAIT
//   coil                  coil drive {A,B,C,D}
//   busy, steps_left      status
module step_sequencer #(
  parameter int STEP_W  = 8,
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic               cmd_dir,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic               cmd_half,
  input  logic               abort,
  output logic               dly_start,
  output logic               dly_enable,
  output logic [DELAY_W-1:0] dly_value,
  input  logic               dly_done,
  output logic [3:0]         coil,
  output logic               busy,
  output logic [STEP_W-1:0]  steps_left
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STEP} state_t;

  // 8-entry half-step table; even indices are the full-step (single-coil) phases.
  function automatic logic [3:0] phase_coil(input logic [2:0] idx);
    logic [3:0] c;
    case (idx)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1100;
      3'd2:    c = 4'b0100;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b0011;
      3'd6:    c = 4'b0001;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [DELAY_W-1:0] dval_q, dval_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;
  logic [3:0]         coil_q;
  logic               start_q, en_q, busy_q;

  logic               accept;
  logic [2:0]         step_sz;

  assign cmd_ready = (state_q == S_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign step_sz   = half_q ? 3'd1 : 3'd2;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    steps_d = steps_q;
    dval_d  = dval_q;
    dir_d   = dir_q;
    half_d  = half_q;
    case (state_q)
      S_IDLE: begin
        // A zero-length command is consumed without touching anything.
        if (accept && (cmd_steps != '0)) begin
          dir_d   = cmd_dir;
          half_d  = cmd_half;
          dval_d  = cmd_delay;
          steps_d = cmd_steps;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: if (dly_done) state_d = S_STEP;
      S_STEP: begin
        // 3-bit index arithmetic wraps mod 8 on its own.
        idx_d   = dir_q ? (idx_q + step_sz) : (idx_q - step_sz);
        steps_d = steps_q - STEP_W'(1);
        state_d = (steps_d == '0) ? S_IDLE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything in an active command; coil stays where it is.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      steps_d = '0;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      steps_q <= '0;
      dval_q  <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      coil_q  <= 4'b1000;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
      dval_q  <= dval_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      // Outputs are registered from the next state so they line up exactly
      // with the state register and never glitch on input changes.
      coil_q  <= phase_coil(idx_d);
      start_q <= (state_d == S_LOAD);
      en_q    <= (state_d == S_WAIT);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign dly_start  = start_q;
  assign dly_enable = en_q;
  assign dly_value  = dval_q;
  assign coil       = coil_q;
  assign busy       = busy_q;
  assign steps_left = steps_q;

endmodule
